// File: rtl/syncdivider_multi_if.sv
// Sync-divider control/observation bundle: the sync source and push-button side
// drive through master, the divider sits on slave.
interface syncdivider_multi_if #(
    parameter int NCHAN = 4,
    parameter int SELW  = 2,
    parameter int CW    = 3
);
    logic              sync_in;
    logic              restart;
    logic [SELW-1:0]   sel_chan;
    logic              pb_divby;
    logic              pb_offset;
    logic              pb_mute;
    logic [NCHAN-1:0]  sync_out;
    logic [NCHAN-1:0]  muted;
    logic [CW-1:0]     beat_count;
    logic [CW:0]       disp_divby;
    logic [CW-1:0]     disp_offset;
    logic              update_pending;

    modport master (
        output sync_in, restart, sel_chan, pb_divby, pb_offset, pb_mute,
        input  sync_out, muted, beat_count, disp_divby, disp_offset, update_pending
    );

    modport slave (
        input  sync_in, restart, sel_chan, pb_divby, pb_offset, pb_mute,
        output sync_out, muted, beat_count, disp_divby, disp_offset, update_pending
    );
endinterface

// File: rtl/syncdivider_multi.sv
// Multi-channel power-of-two sync divider with per-channel offset and mute.
// Define SYNCDIV_DEFER_EN to defer divider/offset edits to the next bar boundary.
module syncdivider_multi #(
    parameter int NCHAN = 4,
    parameter int SELW  = 2,
    parameter int CW    = 3,
    parameter int EXPW  = 2
) (
    input logic                CLK,
    input logic                RST,
    syncdivider_multi_if.slave bus
);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EXPW-1:0]  exp_q [NCHAN];
    logic [EXPW-1:0]  exp_d [NCHAN];
    logic [CW-1:0]    off_q [NCHAN];
    logic [CW-1:0]    off_d [NCHAN];
    logic [NCHAN-1:0] mute_q, mute_d;
    logic [NCHAN-1:0] sel_hit;
    logic [NCHAN-1:0] pulse;
    logic [CW-1:0]    ceff;
    logic [CW-1:0]    phase;

`ifdef SYNCDIV_DEFER_EN
    logic [EXPW-1:0]  pexp_q [NCHAN];
    logic [EXPW-1:0]  pexp_d [NCHAN];
    logic [CW-1:0]    poff_q [NCHAN];
    logic [CW-1:0]    poff_d [NCHAN];
    logic             pend_q, pend_d;
    logic             boundary;
`endif

    function automatic logic [CW-1:0] low_mask(input logic [EXPW-1:0] e);
        logic [CW:0] m;
        m = ((CW+1)'(1) << e) - (CW+1)'(1);
        return m[CW-1:0];
    endfunction

    function automatic logic [EXPW-1:0] step_exp(input logic [EXPW-1:0] e);
        return (e == EXPW'(CW)) ? '0 : e + EXPW'(1);
    endfunction

    // Decoding by comparison keeps out-of-range selects from matching any channel.
    always_comb begin
        sel_hit = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (bus.sel_chan == SELW'(c)) sel_hit[c] = 1'b1;
        end
    end

    always_comb begin
        pulse = '0;
        phase = '0;
        ceff  = bus.restart ? '0 : cnt_q;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            phase    = ceff - off_q[c];
            pulse[c] = bus.sync_in & ~mute_q[c] & ((phase & low_mask(exp_q[c])) == '0);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.restart)      cnt_d = bus.sync_in ? CW'(1) : '0;
        else if (bus.sync_in) cnt_d = cnt_q + CW'(1);

        mute_d = mute_q ^ (sel_hit & {NCHAN{bus.pb_mute}});

        for (int unsigned c = 0; c < NCHAN; c++) begin
            exp_d[c] = exp_q[c];
            off_d[c] = off_q[c];
        end

`ifdef SYNCDIV_DEFER_EN
        boundary = bus.restart | (bus.sync_in & (cnt_q == '1));
        for (int unsigned c = 0; c < NCHAN; c++) begin
            pexp_d[c] = pexp_q[c];
            poff_d[c] = poff_q[c];
            if (boundary) begin
                exp_d[c] = pexp_q[c];
                off_d[c] = poff_q[c];
            end
            if (sel_hit[c] && bus.pb_divby)  pexp_d[c] = step_exp(pexp_q[c]);
            if (sel_hit[c] && bus.pb_offset) poff_d[c] = poff_q[c] + CW'(1);
        end
        // An edit landing on a boundary stays pending for the following one.
        pend_d = ((|sel_hit) & (bus.pb_divby | bus.pb_offset)) | (pend_q & ~boundary);
`else
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (sel_hit[c] && bus.pb_divby)  exp_d[c] = step_exp(exp_q[c]);
            if (sel_hit[c] && bus.pb_offset) off_d[c] = off_q[c] + CW'(1);
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            mute_q <= '0;
            for (int unsigned c = 0; c < NCHAN; c++) begin
                exp_q[c] <= '0;
                off_q[c] <= '0;
`ifdef SYNCDIV_DEFER_EN
                pexp_q[c] <= '0;
                poff_q[c] <= '0;
`endif
            end
`ifdef SYNCDIV_DEFER_EN
            pend_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            mute_q <= mute_d;
            for (int unsigned c = 0; c < NCHAN; c++) begin
                exp_q[c] <= exp_d[c];
                off_q[c] <= off_d[c];
`ifdef SYNCDIV_DEFER_EN
                pexp_q[c] <= pexp_d[c];
                poff_q[c] <= poff_d[c];
`endif
            end
`ifdef SYNCDIV_DEFER_EN
            pend_q <= pend_d;
`endif
        end
    end

    always_comb begin
        bus.disp_divby  = '0;
        bus.disp_offset = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (sel_hit[c]) begin
`ifdef SYNCDIV_DEFER_EN
                bus.disp_divby  = (CW+1)'(1) << pexp_q[c];
                bus.disp_offset = poff_q[c];
`else
                bus.disp_divby  = (CW+1)'(1) << exp_q[c];
                bus.disp_offset = off_q[c];
`endif
            end
        end
    end

    assign bus.sync_out   = RST ? '0 : pulse;
    assign bus.muted      = mute_q;
    assign bus.beat_count = cnt_q;
`ifdef SYNCDIV_DEFER_EN
    assign bus.update_pending = pend_q;
`else
    assign bus.update_pending = 1'b0;
`endif

endmodule

// File: tb/tb_syncdivider_multi.sv
// Scoreboard bench for syncdivider_multi: stimulus queues expected sync_out per
// sync pulse, a negedge monitor pops and compares.
module tb_syncdivider_multi;
    localparam int NCHAN = 4;
    localparam int SELW  = 3;
    localparam int CW    = 3;
    localparam int EXPW  = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    syncdivider_multi_if #(.NCHAN(NCHAN), .SELW(SELW), .CW(CW)) bus ();

    syncdivider_multi #(.NCHAN(NCHAN), .SELW(SELW), .CW(CW), .EXPW(EXPW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int nvec  = 0;
    int nfail = 0;
    logic [NCHAN-1:0] expq [$];
    logic [NCHAN-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            nvec++;
            if (bus.sync_in) begin
                if (expq.size() == 0) begin
                    nfail++;
                    $display("FAIL sync_out: got %b with no expected pulse queued", bus.sync_out);
                end else begin
                    mon_exp = expq.pop_front();
                    if (bus.sync_out !== mon_exp) begin
                        nfail++;
                        $display("FAIL sync_out: got %b expected %b (beat %0d)",
                                 bus.sync_out, mon_exp, bus.beat_count);
                    end
                end
            end else if (bus.sync_out !== '0) begin
                nfail++;
                $display("FAIL sync_out_idle: got %b expected 0000", bus.sync_out);
            end
        end
    end

    // One clock cycle of stimulus, starting just after a rising edge.
    task automatic step(input logic s, input logic r, input logic db, input logic po,
                        input logic pm, input logic [NCHAN-1:0] ex);
        bus.sync_in   = s;
        bus.restart   = r;
        bus.pb_divby  = db;
        bus.pb_offset = po;
        bus.pb_mute   = pm;
        if (s) expq.push_back(ex);
        @(posedge CLK);
        #1;
        bus.sync_in   = 1'b0;
        bus.restart   = 1'b0;
        bus.pb_divby  = 1'b0;
        bus.pb_offset = 1'b0;
        bus.pb_mute   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sync(input logic [NCHAN-1:0] ex);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex);
    endtask

    task automatic restart_only();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.sync_in   = 1'b0;
        bus.restart   = 1'b0;
        bus.sel_chan  = '0;
        bus.pb_divby  = 1'b0;
        bus.pb_offset = 1'b0;
        bus.pb_mute   = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        bus.sync_in = 1'b1;
        #1;
        check("rst_sync_out", 32'(bus.sync_out), 32'h0);
        bus.sync_in = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_beat_count", 32'(bus.beat_count), 0);
        check("rst_muted", 32'(bus.muted), 0);
        check("rst_disp_divby", 32'(bus.disp_divby), 1);
        check("rst_disp_offset", 32'(bus.disp_offset), 0);
        check("rst_update_pending", 32'(bus.update_pending), 0);

        // 1: every channel follows every beat
        for (int i = 0; i < 8; i++) begin
            sync(4'b1111);
            idle(3);
        end
        check("t1_beat_count", 32'(bus.beat_count), 0);

        // 2: ch1 divide by 4, offset 1
        bus.sel_chan = 3'd1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("t2_disp_divby", 32'(bus.disp_divby), 4);
        check("t2_disp_offset", 32'(bus.disp_offset), 1);
        restart_only();
        for (int lap = 0; lap < 2; lap++) begin
            for (int k = 0; k < 8; k++) begin
                sync((k == 1 || k == 5) ? 4'b1111 : 4'b1101);
            end
        end
        check("t2_beat_count", 32'(bus.beat_count), 0);

        // 3: mute ch2
        bus.sel_chan = 3'd2;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("t3_muted_on", 32'(bus.muted), 4);
        for (int k = 0; k < 8; k++) begin
            sync((k == 1 || k == 5) ? 4'b1011 : 4'b1001);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("t3_muted_off", 32'(bus.muted), 0);
        sync(4'b1101);

        // 4: ch0 divide by 8, restart coincident with sync
        bus.sel_chan = 3'd0;
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("t4_disp_divby8", 32'(bus.disp_divby), 8);
        restart_only();
        sync(4'b1101);
        sync(4'b1110);
        sync(4'b1100);
        sync(4'b1100);
        sync(4'b1100);
        check("t4_beat_before", 32'(bus.beat_count), 5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
        check("t4_beat_after_restart", 32'(bus.beat_count), 1);
        restart_only();
        check("t4_beat_restart_only", 32'(bus.beat_count), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        restart_only();
        check("t4_divby_wrap", 32'(bus.disp_divby), 1);

        // 5: out-of-range selects are ignored
        bus.sel_chan = 3'd6;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
        check("t5_sel6_divby", 32'(bus.disp_divby), 0);
        check("t5_sel6_offset", 32'(bus.disp_offset), 0);
        bus.sel_chan = 3'd4;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
        check("t5_sel4_divby", 32'(bus.disp_divby), 0);
        check("t5_muted", 32'(bus.muted), 0);
        check("t5_update_pending", 32'(bus.update_pending), 0);
        bus.sel_chan = 3'd1;
        #1;
        check("t5_ch1_divby", 32'(bus.disp_divby), 4);
        check("t5_ch1_offset", 32'(bus.disp_offset), 1);
        bus.sel_chan = 3'd2;
        #1;
        check("t5_ch2_divby", 32'(bus.disp_divby), 1);
        check("t5_ch2_offset", 32'(bus.disp_offset), 0);
        bus.sel_chan = 3'd0;
        #1;
        check("t5_ch0_divby", 32'(bus.disp_divby), 1);
        sync(4'b1101);

        // edit in the same cycle as sync leaves that cycle untouched
        bus.sel_chan = 3'd2;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        check("mute_with_sync", 32'(bus.muted), 4);
        sync(4'b1001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("mute_restore", 32'(bus.muted), 0);
        check("pre_t6_beat", 32'(bus.beat_count), 3);

        // 6: ch3 divide by 2 requested at beat 3
        bus.sel_chan = 3'd3;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("t6_disp_divby", 32'(bus.disp_divby), 2);
`ifdef SYNCDIV_DEFER_EN
        check("t6_pending_set", 32'(bus.update_pending), 1);
        sync(4'b1101);
        sync(4'b1101);
        sync(4'b1111);
        sync(4'b1101);
        sync(4'b1101);
        check("t6_pending_clear", 32'(bus.update_pending), 0);
        check("t6_beat_wrap", 32'(bus.beat_count), 0);
        sync(4'b1101);
        sync(4'b0111);
        sync(4'b1101);
        sync(4'b0101);
        sync(4'b1101);
        sync(4'b0111);
        sync(4'b1101);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101);
        check("t6_edit_at_boundary", 32'(bus.update_pending), 1);
        check("t6_pending_offset", 32'(bus.disp_offset), 1);
        restart_only();
        check("t6_restart_applies", 32'(bus.update_pending), 0);
        sync(4'b0101);
`else
        check("t6_no_pending", 32'(bus.update_pending), 0);
        sync(4'b0101);
        sync(4'b1101);
        sync(4'b0111);
        sync(4'b1101);
        sync(4'b0101);
        check("t6_beat_wrap", 32'(bus.beat_count), 0);
`endif

        idle(2);
        check("scoreboard_drain", 32'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/syncdivider_multi.md
Name: syncdivider_multi

Overview:
- Parametrised multi-channel successor of the single-channel sync divider.
- One shared input-sync counter feeds NCHAN independent outputs. Each output has its own power-of-two divider, offset and mute.
- Settings are edited through shared push-button strobes addressed by sel_chan.
- Sits between the master sync source and the per-voice sequencer or MIDI-clock consumers.

Parameters:
- NCHAN, 4, number of output channels (1..16).
- SELW, 2, width of sel_chan; must satisfy NCHAN <= 2**SELW.
- CW, 3, shared counter width. Max divider 2**CW; offsets 0..2**CW-1.
- EXPW, 2, divider-exponent register width. Exponent range 0..CW; requires CW < 2**EXPW.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- sync_in  in  1  input sync pulse, high exactly one cycle per beat.
- restart  in  1  one-cycle strobe; realigns the shared counter to 0.
- sel_chan  in  SELW  channel addressed by the push-button strobes and the display outputs.
- pb_divby  in  1  one-cycle strobe; steps the divider of sel_chan.
- pb_offset  in  1  one-cycle strobe; steps the offset of sel_chan.
- pb_mute  in  1  one-cycle strobe; toggles the mute of sel_chan.
- sync_out  out  NCHAN  divided sync pulses, one bit per channel.
- muted  out  NCHAN  current mute flags.
- beat_count  out  CW  shared counter value.
- disp_divby  out  CW+1  divider of sel_chan (1<<exp), for the 7-seg display.
- disp_offset  out  CW  offset of sel_chan.
- update_pending  out  1  deferred edit awaiting application (see Optional Feature).

Behaviour:
- Reset (RST high at a clock edge):
  - cnt=0; all exp=0, off=0, mute=0.
  - Pending registers are cleared.
  - sync_out is forced to all-zero while RST is high.
- Shared counter cnt:
  - On sync_in: cnt <= cnt+1, wrapping mod 2**CW.
  - If restart is high: cnt <= sync_in ? 1 : 0. restart has priority, and the current beat counts as beat 0.
- sync_out[c] is combinational with zero latency, in the same cycle as sync_in:
  - sync_out[c] = sync_in & ~mute[c] & ((ceff - off[c]) mod 2**CW has its low exp[c] bits all zero).
  - ceff = 0 when restart is high, otherwise cnt, evaluated before the increment.
  - exp=0 gives every sync; exp=CW gives one pulse per 2**CW syncs.
  - With no sync_in, all outputs are 0. Each output pulse lasts exactly one cycle.
- Edits apply only when sel_chan < NCHAN; otherwise strobes are ignored and disp_divby=disp_offset=0.
  - pb_divby: exp[sel] <= (exp==CW) ? 0 : exp+1.
  - pb_offset: off[sel] <= off+1 mod 2**CW.
  - pb_mute: mute[sel] <= ~mute[sel].
- Simultaneous strobes all apply in the same cycle.
- An edit in the same cycle as sync_in does not affect that cycle's sync_out; the new value takes effect from the next cycle.
- Display:
  - disp_divby = 1<<exp[sel_chan]; disp_offset = off[sel_chan].
  - Both are combinational from sel_chan.
- muted mirrors the mute registers; beat_count mirrors cnt.

Optional Feature:
- Macro: SYNCDIV_DEFER_EN.
- Defined:
  - pb_divby and pb_offset modify per-channel pending exp/off registers, initialised equal to the active ones.
  - update_pending goes high the cycle after any such edit.
  - Pending values copy into the active registers at the clock edge of a bar boundary: sync_in with cnt == 2**CW-1, or restart. update_pending then clears.
  - sync_out in the boundary cycle uses the old values.
  - The display shows pending values.
  - pb_mute is always immediate.
  - An edit in the same cycle as a boundary is kept pending for the next boundary.
- Undefined:
  - Edits are immediate; update_pending is tied 0.
  - No pending registers are synthesised.

Test Plan (NCHAN=4, CW=3, SELW=3):
1. Reset, then 8 sync_in pulses spaced 4 cycles apart -> sync_out[0..3] pulse on all 8 beats, coincident with sync_in; beat_count ends at 0.
2. sel_chan=1, pb_divby x2, pb_offset x1; then 16 syncs from cnt=0 -> sync_out[1] only at cnt=1,5 in both laps; disp_divby=4, disp_offset=1.
3. sel_chan=2, pb_mute -> muted=4'b0100, no sync_out[2] for 8 syncs; pb_mute again -> pulses resume on the next sync.
4. ch0 at exp=3, off=0; run to cnt=5, then assert restart with sync_in -> sync_out[0]=1 that cycle, beat_count=1 afterwards.
5. sel_chan=6 with pb_divby/pb_offset/pb_mute -> no register change; disp_divby=0, disp_offset=0.
6. SYNCDIV_DEFER_EN defined: ch3 at exp=0; pb_divby at cnt=3 -> update_pending=1 and ch3 keeps pulsing every sync through cnt=7. After the wrap, ch3 pulses every 2nd sync and update_pending=0.
